// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder sequencer around an external combinational 4-bit ripple slice.
// Operands come in over a valid/ready handshake and leave after NIBBLES slice passes, LSB nibble first.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic [3:0]       add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [NIBBLES-1:0][3:0] nib_vec_t;

    state_t   state, state_nxt;
    logic [IW-1:0] idx;
    nib_vec_t a_reg, b_reg, res_reg;
    logic     carry_reg;
    logic     ovf_reg;

    logic     accept;
    logic     last_nib;
    logic     handoff;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/slice outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_cin   = 1'b0;
        accept    = 1'b0;
        last_nib  = 1'b0;
        handoff   = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                add_a    = a_reg[idx];
                add_b    = b_reg[idx];
                add_cin  = carry_reg;
                last_nib = (idx == LAST_IDX);
                if (last_nib) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    handoff   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, per-nibble sum write-back, carry chaining
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= op_cin;
            idx       <= '0;
        end else if (state == RUN) begin
            // The slice is combinational: its outputs reflect this cycle's drive.
            res_reg[idx] <= add_sum;
            carry_reg    <= add_cout[3];
            if (last_nib) begin
                idx     <= '0;
                ovf_reg <= add_cout[3] ^ add_cout[2];
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign result    = res_reg;
    assign carry_out = carry_reg;
    assign overflow  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (WIDTH=16): directed vector table, reset corner case, random ops.
// A behavioural 4-bit ripple slice sits on the add_* ports.
module tb_nibble_serial_adder_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a, op_b;
    logic          op_cin;
    logic [3:0]    add_a, add_b, add_sum, add_cout;
    logic          add_cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow)
    );

    // Bit-level ripple slice
    always_comb begin
        logic c;
        add_sum  = 4'd0;
        add_cout = 4'd0;
        c = add_cin;
        for (int i = 0; i < 4; i++) begin
            add_sum[i]  = add_a[i] ^ add_b[i] ^ c;
            c           = (add_a[i] & add_b[i]) | (add_a[i] & c) | (add_b[i] & c);
            add_cout[i] = c;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         co;
        logic         ovf;
        int           stall;
        bit           pulse;
    } vec_t;

    // One full operation: issue, check per-RUN-cycle slice drive, latency, result, stall hold, handoff.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] er, input logic eco, input logic eovf,
                          input int stall, input bit pulse);
        int cyc;
        int k;
        bit ok_drive;
        bit ok_hold;
        logic [W:0] part;
        logic [W:0] mask;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready_before_op", {31'd0, in_ready}, 32'd1);
        op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
        ok_drive = 1'b1;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            k = cyc - 1;
            if (k < N) begin
                mask = (17'd1 << (4 * k)) - 17'd1;
                part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'd0, cin};
                if (add_a !== a[4*k +: 4] || add_b !== b[4*k +: 4] ||
                    add_cin !== part[4*k] || in_ready !== 1'b0)
                    ok_drive = 1'b0;
            end else begin
                ok_drive = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, N + 1);
        chk("run_drive", {31'd0, ok_drive}, 32'd1);
        chk("result", {16'd0, result}, {16'd0, er});
        chk("carry_out", {31'd0, carry_out}, {31'd0, eco});
        chk("overflow", {31'd0, overflow}, {31'd0, eovf});
        chk("done_slice_idle", {23'd0, add_a, add_b, add_cin}, 32'd0);
        ok_hold = 1'b1;
        for (int s = 0; s < stall; s++) begin
            if (pulse) begin
                in_valid = 1'b1; op_a = ~a; op_b = ~b; op_cin = ~cin;
            end
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er ||
                carry_out !== eco || overflow !== eovf)
                ok_hold = 1'b0;
        end
        if (stall > 0) chk("stall_hold", {31'd0, ok_hold}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handoff_state", {30'd0, out_valid, in_ready}, 32'd1);
        chk("idle_result_held", {15'd0, carry_out, result}, {15'd0, eco, er});
    endtask

    initial begin
        vec_t vecs[7];
        logic [W:0]   full;
        logic [W-1:0] ra, rb;
        logic         rc, rovf;
        int           cyc;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0,  1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0,  1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0,  1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 10, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 2,  1'b0};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0,  1'b0};
        vecs[6] = '{16'h4000, 16'h4000, 1'b1, 16'h8001, 1'b0, 1'b1, 3,  1'b1};

        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
        chk("rst_result", {14'd0, overflow, carry_out, result}, 32'd0);
        chk("rst_slice_drive", {23'd0, add_a, add_b, add_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_valid", {30'd0, in_ready, out_valid}, 32'd2);

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].co,
                   vecs[i].ovf, vecs[i].stall, vecs[i].pulse);

        // Reset during the 3rd RUN cycle abandons the op
        op_a = 16'hABCD; op_b = 16'h1111; op_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_rst_state", {30'd0, in_ready, out_valid}, 32'd2);
        chk("midrun_rst_result", {15'd0, carry_out, result}, 32'd0);
        cyc = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) cyc++;
        end
        chk("midrun_rst_no_output", cyc, 0);
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            rovf = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
            run_op(ra, rb, rc, full[W-1:0], full[W], rovf, $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
